// File: rtl/alu_ic_arbiter_if.sv
// Requester/ALU/response bundle between two ALU-cluster requesters and the arbiter.
// The master side drives the requests, the ALU result and rsp_ready. The slave side is the arbiter.
interface alu_ic_arbiter_if #(
   parameter int OPW  = 8,
   parameter int DW   = 64,
   parameter int TAGW = 4
);
   logic            r0_valid, r1_valid;
   logic            r0_ready, r1_ready;
   logic [OPW-1:0]  r0_op, r1_op;
   logic            r0_multi, r1_multi;
   logic [TAGW-1:0] r0_tag, r1_tag;
   logic            alu_issue;
   logic            alu_sel;
   logic [OPW-1:0]  alu_op;
   logic            alu_multi;
   logic [DW-1:0]   alu_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [TAGW-1:0] rsp_tag;
   logic [DW-1:0]   rsp_data;

   modport master (
      output r0_valid, r1_valid, r0_op, r1_op, r0_multi, r1_multi, r0_tag, r1_tag,
      output alu_result, rsp_ready,
      input  r0_ready, r1_ready, alu_issue, alu_sel, alu_op, alu_multi,
      input  rsp_valid, rsp_id, rsp_tag, rsp_data
   );

   modport slave (
      input  r0_valid, r1_valid, r0_op, r1_op, r0_multi, r1_multi, r0_tag, r1_tag,
      input  alu_result, rsp_ready,
      output r0_ready, r1_ready, alu_issue, alu_sel, alu_op, alu_multi,
      output rsp_valid, rsp_id, rsp_tag, rsp_data
   );
endinterface

// File: rtl/alu_ic_arbiter.sv
// Two-requester arbiter for the ALU cluster. r0 has priority, and r1 gets a starvation guard.
// One op is in flight at a time. The response is held until the consumer accepts it.
module alu_ic_arbiter #(
   parameter int OPW        = 8,
   parameter int DW         = 64,
   parameter int TAGW       = 4,
   parameter int SHUF_LAT   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   alu_ic_arbiter_if.slave     bus,
   output logic [1:0]          dbg_state_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

   localparam logic [3:0] SC_MAX   = 4'(STARVE_MAX);
   localparam logic [3:0] CNT_INIT = 4'(SHUF_LAT - 1);
   localparam bit         MULTI_EN = (SHUF_LAT > 1);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      sc_q, sc_d;
   logic            rsp_id_q, rsp_id_d;
   logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
   logic [DW-1:0]   rsp_data_q, rsp_data_d;

   logic            can_issue, issue, grant_r1, grant_multi;
   logic [OPW-1:0]  grant_op;
   logic [TAGW-1:0] grant_tag;

   // Issue is allowed from IDLE, or from RESP when the held response retires this cycle
   assign can_issue   = ~rst & ~flush &
                        ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
   assign grant_r1    = bus.r1_valid & (~bus.r0_valid | (sc_q == SC_MAX));
   assign issue       = can_issue & (bus.r0_valid | bus.r1_valid);
   assign grant_multi = grant_r1 ? bus.r1_multi : bus.r0_multi;
   assign grant_op    = grant_r1 ? bus.r1_op    : bus.r0_op;
   assign grant_tag   = grant_r1 ? bus.r1_tag   : bus.r0_tag;

   assign bus.r0_ready  = issue & ~grant_r1;
   assign bus.r1_ready  = issue & grant_r1;
   assign bus.alu_issue = issue;
   assign bus.alu_sel   = issue & grant_r1;
   assign bus.alu_op    = issue ? grant_op : '0;
   assign bus.alu_multi = issue & grant_multi;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_tag   = rsp_tag_q;
   assign bus.rsp_data  = rsp_data_q;
   assign dbg_state_o   = state_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sc_d       = sc_q;
      rsp_id_d   = rsp_id_q;
      rsp_tag_d  = rsp_tag_q;
      rsp_data_d = rsp_data_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         sc_d    = '0;
      end else begin
         // sc counts r0 wins only while r1 is actually waiting
         if (!bus.r1_valid || (issue && grant_r1))
            sc_d = '0;
         else if (issue && sc_q != SC_MAX)
            sc_d = sc_q + 4'd1;

         case (state_q)
            IDLE, RESP: begin
               if (issue) begin
                  rsp_id_d  = grant_r1;
                  rsp_tag_d = grant_tag;
                  if (grant_multi && MULTI_EN) begin
                     state_d = BUSY;
                     cnt_d   = CNT_INIT;
                  end else begin
                     state_d    = RESP;
                     rsp_data_d = bus.alu_result;
                  end
               end else if (state_q == RESP && bus.rsp_ready) begin
                  state_d = IDLE;
               end
            end
            BUSY: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d    = RESP;
                  rsp_data_d = bus.alu_result;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sc_q       <= '0;
         rsp_id_q   <= 1'b0;
         rsp_tag_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sc_q       <= sc_d;
         rsp_id_q   <= rsp_id_d;
         rsp_tag_q  <= rsp_tag_d;
         rsp_data_q <= rsp_data_d;
      end
   end
endmodule

// File: tb/tb_alu_ic_arbiter.sv
// Bench for alu_ic_arbiter: dut_a uses SHUF_LAT=2 and dut_b uses SHUF_LAT=4, both with STARVE_MAX=4.
// Inputs are driven 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_alu_ic_arbiter;
   localparam int OPW  = 8;
   localparam int DW   = 64;
   localparam int TAGW = 4;
   localparam int EW   = 1 + TAGW + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_a = 1'b0;
   logic flush_b = 1'b0;
   logic [1:0] st_a, st_b;

   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;

   always #5 clk = ~clk;

   alu_ic_arbiter_if #(.OPW(OPW), .DW(DW), .TAGW(TAGW)) a_if ();
   alu_ic_arbiter_if #(.OPW(OPW), .DW(DW), .TAGW(TAGW)) b_if ();

   alu_ic_arbiter #(.OPW(OPW), .DW(DW), .TAGW(TAGW), .SHUF_LAT(2), .STARVE_MAX(4)) dut_a (
      .clk(clk), .rst(rst), .flush(flush_a), .bus(a_if.slave), .dbg_state_o(st_a)
   );
   alu_ic_arbiter #(.OPW(OPW), .DW(DW), .TAGW(TAGW), .SHUF_LAT(4), .STARVE_MAX(4)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .bus(b_if.slave), .dbg_state_o(st_b)
   );

   task automatic idle_inputs();
      a_if.r0_valid = 0; a_if.r1_valid = 0; a_if.r0_op = '0; a_if.r1_op = '0;
      a_if.r0_multi = 0; a_if.r1_multi = 0; a_if.r0_tag = '0; a_if.r1_tag = '0;
      a_if.alu_result = '0; a_if.rsp_ready = 1;
      b_if.r0_valid = 0; b_if.r1_valid = 0; b_if.r0_op = '0; b_if.r1_op = '0;
      b_if.r0_multi = 0; b_if.r1_multi = 0; b_if.r0_tag = '0; b_if.r1_tag = '0;
      b_if.alu_result = '0; b_if.rsp_ready = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      a_if.r0_valid = 1; a_if.r0_op = 8'h5A;
      @(posedge clk); @(posedge clk); #2;
      n_checks++;
      if ({a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.alu_op} !== 11'd0)
         $display("FAIL reset_outputs: got %h exp 0",
                  {a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.alu_op});
      else n_pass++;
      @(posedge clk); #1;
      rst = 0; a_if.r0_valid = 0;
      #1;
      n_checks++;
      if ({st_a, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== 72'd0)
         $display("FAIL reset_state: st=%0d vld=%b tag=%h data=%h exp all 0",
                  st_a, a_if.rsp_valid, a_if.rsp_tag, a_if.rsp_data);
      else n_pass++;
   endtask

   task automatic test_single_b2b();
      @(posedge clk); #1;
      a_if.r0_valid = 1; a_if.r0_op = 8'h21; a_if.r0_tag = 4'd3; a_if.r0_multi = 0;
      a_if.alu_result = 64'h55; a_if.rsp_ready = 1;
      #1;
      n_checks++;
      if ({a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.alu_sel, a_if.alu_op, a_if.rsp_valid}
          !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h21, 1'b0})
         $display("FAIL single_issue: rdy0=%b rdy1=%b iss=%b sel=%b op=%h vld=%b exp 1 0 1 0 21 0",
                  a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.alu_sel, a_if.alu_op,
                  a_if.rsp_valid);
      else n_pass++;
      exp_q.push_back({1'b0, 4'd3, 64'h55});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i < 4) begin
            a_if.r0_tag = 4'(i + 4);
            a_if.r0_op = 8'($urandom_range(0, 255));
            a_if.alu_result = {$urandom, $urandom};
         end else a_if.r0_valid = 0;
         #1;
         exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
            $display("FAIL b2b_rsp[%0d]: got vld=%b %h exp vld=1 %h", i, a_if.rsp_valid,
                     {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
         else n_pass++;
         if (i < 4) begin
            n_checks++;
            if ({a_if.r0_ready, a_if.alu_issue, a_if.alu_op} !== {1'b1, 1'b1, a_if.r0_op})
               $display("FAIL b2b_issue[%0d]: rdy=%b iss=%b op=%h exp 1 1 %h", i,
                        a_if.r0_ready, a_if.alu_issue, a_if.alu_op, a_if.r0_op);
            else n_pass++;
            exp_q.push_back({1'b0, a_if.r0_tag, a_if.alu_result});
         end
      end
      @(posedge clk); #2;
      n_checks++;
      if ({a_if.rsp_valid, st_a} !== 3'b0_00)
         $display("FAIL b2b_idle: vld=%b st=%0d exp 0 0", a_if.rsp_valid, st_a);
      else n_pass++;
   endtask

   task automatic test_multi();
      @(posedge clk); #1;
      a_if.r1_valid = 1; a_if.r1_multi = 1; a_if.r1_op = 8'h33; a_if.r1_tag = 4'd5;
      a_if.alu_result = 64'hEE;
      #1;
      n_checks++;
      if ({a_if.r1_ready, a_if.r0_ready, a_if.alu_sel, a_if.alu_multi, a_if.alu_op}
          !== {4'b1011, 8'h33})
         $display("FAIL multi_issue: rdy1=%b rdy0=%b sel=%b multi=%b op=%h exp 1 0 1 1 33",
                  a_if.r1_ready, a_if.r0_ready, a_if.alu_sel, a_if.alu_multi, a_if.alu_op);
      else n_pass++;
      exp_q.push_back({1'b1, 4'd5, 64'hAB});
      @(posedge clk); #1;
      a_if.r1_valid = 0; a_if.r1_multi = 0; a_if.alu_result = 64'hAB;
      a_if.r0_valid = 1; a_if.r0_tag = 4'd7; a_if.r0_op = 8'h44;
      #1;
      n_checks++;
      if ({a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.rsp_valid, st_a} !== 6'b0000_01)
         $display("FAIL multi_busy: rdy0=%b rdy1=%b iss=%b vld=%b st=%0d exp 0 0 0 0 1",
                  a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.rsp_valid, st_a);
      else n_pass++;
      @(posedge clk); #1;
      a_if.alu_result = 64'h10;
      #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
         $display("FAIL multi_rsp: got vld=%b %h exp vld=1 %h", a_if.rsp_valid,
                  {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
      else n_pass++;
      n_checks++;
      if (a_if.r0_ready !== 1'b1)
         $display("FAIL multi_next_issue: rdy0=%b exp 1", a_if.r0_ready);
      else n_pass++;
      exp_q.push_back({1'b0, 4'd7, 64'h10});
      @(posedge clk); #1;
      a_if.r0_valid = 0;
      #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
         $display("FAIL multi_rsp2: got vld=%b %h exp vld=1 %h", a_if.rsp_valid,
                  {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
      else n_pass++;
      @(posedge clk); #2;
   endtask

   task automatic test_starve();
      logic       exp_sel;
      logic [7:0] exp_op;
      @(posedge clk); #1;
      a_if.r0_valid = 1; a_if.r1_valid = 1; a_if.r0_multi = 0; a_if.r1_multi = 0;
      a_if.r0_tag = 4'd1; a_if.r1_tag = 4'd2; a_if.r0_op = 8'h01; a_if.r1_op = 8'h02;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         a_if.alu_result = {$urandom, $urandom};
         #1;
         exp_sel = ((i % 5) == 4);
         exp_op = exp_sel ? 8'h02 : 8'h01;
         n_checks++;
         if ({a_if.r0_ready, a_if.r1_ready, a_if.alu_sel, a_if.alu_op}
             !== {~exp_sel, exp_sel, exp_sel, exp_op})
            $display("FAIL starve_grant[%0d]: rdy0=%b rdy1=%b sel=%b op=%h exp sel=%b", i,
                     a_if.r0_ready, a_if.r1_ready, a_if.alu_sel, a_if.alu_op, exp_sel);
         else n_pass++;
         if (i > 0) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
               $display("FAIL starve_rsp[%0d]: got vld=%b %h exp vld=1 %h", i, a_if.rsp_valid,
                        {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
            else n_pass++;
         end
         exp_q.push_back({exp_sel, exp_sel ? 4'd2 : 4'd1, a_if.alu_result});
      end
      @(posedge clk); #1;
      a_if.r0_valid = 0; a_if.r1_valid = 0;
      #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
         $display("FAIL starve_last_rsp: got vld=%b %h exp vld=1 %h", a_if.rsp_valid,
                  {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
      else n_pass++;
      @(posedge clk); #2;
   endtask

   task automatic test_hold();
      @(posedge clk); #1;
      a_if.r0_valid = 1; a_if.r0_tag = 4'd9; a_if.r0_op = 8'h66; a_if.alu_result = 64'h77;
      a_if.rsp_ready = 1;
      #1;
      n_checks++;
      if (a_if.r0_ready !== 1'b1) $display("FAIL hold_issue: rdy0=%b exp 1", a_if.r0_ready);
      else n_pass++;
      exp_q.push_back({1'b0, 4'd9, 64'h77});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         a_if.rsp_ready = 0; a_if.r0_tag = 4'd10; a_if.alu_result = {$urandom, $urandom};
         #1;
         n_checks++;
         if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data,
              a_if.r0_ready, a_if.r1_ready, a_if.alu_issue}
             !== {1'b1, 1'b0, 4'd9, 64'h77, 3'b000})
            $display("FAIL hold[%0d]: vld=%b id=%b tag=%h data=%h rdy0=%b iss=%b exp 1 0 9 77 0 0",
                     i, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data,
                     a_if.r0_ready, a_if.alu_issue);
         else n_pass++;
      end
      @(posedge clk); #1;
      a_if.rsp_ready = 1; a_if.alu_result = 64'h99;
      #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data, a_if.r0_ready}
          !== {1'b1, exp_e, 1'b1})
         $display("FAIL hold_accept: vld=%b %h rdy0=%b exp vld=1 %h rdy0=1", a_if.rsp_valid,
                  {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, a_if.r0_ready, exp_e);
      else n_pass++;
      exp_q.push_back({1'b0, 4'd10, 64'h99});
      @(posedge clk); #1;
      a_if.r0_valid = 0;
      #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data} !== {1'b1, exp_e})
         $display("FAIL hold_next_rsp: got vld=%b %h exp vld=1 %h", a_if.rsp_valid,
                  {a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data}, exp_e);
      else n_pass++;
      @(posedge clk); #2;
   endtask

   task automatic test_flush();
      @(posedge clk); #1;
      b_if.r0_valid = 1; b_if.r0_multi = 1; b_if.r0_tag = 4'd4; b_if.r0_op = 8'h70;
      #1;
      n_checks++;
      if ({b_if.r0_ready, b_if.alu_multi} !== 2'b11)
         $display("FAIL flush_issue: rdy0=%b multi=%b exp 1 1", b_if.r0_ready, b_if.alu_multi);
      else n_pass++;
      @(posedge clk); #1;
      b_if.r0_valid = 0;
      #1;
      n_checks++;
      if (st_b !== 2'd1) $display("FAIL flush_busy: st=%0d exp 1", st_b);
      else n_pass++;
      @(posedge clk); #1;
      flush_b = 1; b_if.r0_valid = 1; b_if.r0_multi = 0; b_if.r0_tag = 4'd6; b_if.r0_op = 8'h12;
      #1;
      n_checks++;
      if ({b_if.r0_ready, b_if.r1_ready, b_if.alu_issue, b_if.alu_op, b_if.rsp_valid} !== 12'd0)
         $display("FAIL flush_cycle: rdy0=%b iss=%b op=%h vld=%b exp all 0", b_if.r0_ready,
                  b_if.alu_issue, b_if.alu_op, b_if.rsp_valid);
      else n_pass++;
      @(posedge clk); #1;
      flush_b = 0; b_if.alu_result = 64'h42;
      #1;
      n_checks++;
      if ({st_b, b_if.rsp_valid, b_if.r0_ready} !== 4'b00_0_1)
         $display("FAIL flush_after: st=%0d vld=%b rdy0=%b exp 0 0 1", st_b, b_if.rsp_valid,
                  b_if.r0_ready);
      else n_pass++;
      @(posedge clk); #1;
      b_if.r0_valid = 0;
      #1;
      n_checks++;
      if ({b_if.rsp_valid, b_if.rsp_id, b_if.rsp_tag, b_if.rsp_data}
          !== {1'b1, 1'b0, 4'd6, 64'h42})
         $display("FAIL flush_new_rsp: vld=%b id=%b tag=%h data=%h exp 1 0 6 42",
                  b_if.rsp_valid, b_if.rsp_id, b_if.rsp_tag, b_if.rsp_data);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         n_checks++;
         if (b_if.rsp_valid !== 1'b0) $display("FAIL flush_quiet[%0d]: vld=%b exp 0", i, b_if.rsp_valid);
         else n_pass++;
      end
   endtask

   task automatic test_reset_resp();
      @(posedge clk); #1;
      a_if.r0_valid = 1; a_if.r0_tag = 4'd11; a_if.r0_op = 8'h5C; a_if.alu_result = 64'hCC;
      a_if.rsp_ready = 0;
      #1;
      n_checks++;
      if (a_if.r0_ready !== 1'b1) $display("FAIL rstresp_issue: rdy0=%b exp 1", a_if.r0_ready);
      else n_pass++;
      @(posedge clk); #2;
      n_checks++;
      if ({a_if.rsp_valid, a_if.rsp_tag} !== {1'b1, 4'd11})
         $display("FAIL rstresp_held: vld=%b tag=%h exp 1 b", a_if.rsp_valid, a_if.rsp_tag);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1;
      #1;
      n_checks++;
      if ({a_if.r0_ready, a_if.r1_ready, a_if.alu_issue, a_if.alu_op} !== 11'd0)
         $display("FAIL rstresp_during: rdy0=%b iss=%b op=%h exp 0", a_if.r0_ready,
                  a_if.alu_issue, a_if.alu_op);
      else n_pass++;
      @(posedge clk); #1;
      rst = 0; a_if.r0_valid = 0; a_if.rsp_ready = 1;
      #1;
      n_checks++;
      if ({st_a, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data,
           a_if.r0_ready, a_if.alu_issue} !== 74'd0)
         $display("FAIL rstresp_after: st=%0d vld=%b id=%b tag=%h data=%h exp all 0", st_a,
                  a_if.rsp_valid, a_if.rsp_id, a_if.rsp_tag, a_if.rsp_data);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         n_checks++;
         if (a_if.rsp_valid !== 1'b0) $display("FAIL rstresp_quiet[%0d]: vld=%b exp 0", i, a_if.rsp_valid);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single_b2b();
      test_multi();
      test_starve();
      test_hold();
      test_flush();
      test_reset_resp();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d left exp 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_ic_arbiter.md
ALU_IC_ARBITER -- requirements
Module: alu_ic_arbiter

Parameters (name, default, meaning)
- REQ-001 The block SHALL have parameter OPW, default 8: ALU op field width, matching the ALU op width.
- REQ-002 The block SHALL have parameter DW, default 64: result width, matching the SIMD data width.
- REQ-003 The block SHALL have parameter TAGW, default 4: requester tag width.
- REQ-004 The block SHALL have parameter SHUF_LAT, default 2, legal 1..15: cycles from issue to response for multi-cycle (shuffle) ops.
- REQ-005 The block SHALL have parameter STARVE_MAX, default 4, legal 1..15: consecutive r0 grants allowed while r1 waits.

Interface (name direction width meaning)
- REQ-006 The block SHALL have the following ports:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - flush  in  1  synchronous abort of in-flight op.
  - r0_valid, r1_valid  in  1  request present.
  - r0_ready, r1_ready  out  1  request accepted this cycle.
  - r0_op, r1_op  in  OPW  ALU op.
  - r0_multi, r1_multi  in  1  op is multi-cycle (shuffle).
  - r0_tag, r1_tag  in  TAGW  requester tag.
  - alu_issue  out  1  op driven to ALU cluster this cycle.
  - alu_sel  out  1  source of the issued op: 0=r0, 1=r1.
  - alu_op  out  OPW  op to ALU cluster.
  - alu_multi  out  1  issued op is multi-cycle.
  - alu_result  in  DW  ALU cluster result.
  - rsp_valid  out  1  response held.
  - rsp_ready  in  1  consumer accepts the response.
  - rsp_id  out  1  response owner.
  - rsp_tag  out  TAGW  response tag.
  - rsp_data  out  DW  captured result.

Function
- REQ-007 The block SHALL implement FSM states IDLE, BUSY and RESP; the state after reset SHALL be IDLE.
- REQ-008 The block SHALL issue only in IDLE, or in RESP while rsp_ready=1; this gives single-cycle ops a throughput of one per cycle.
- REQ-009 On an issue cycle, the block SHALL assert exactly one of r0_ready/r1_ready, and SHALL drive alu_issue=1 with alu_sel/alu_op/alu_multi taken combinationally from the granted requester.
- REQ-010 Outside issue cycles, the block SHALL hold r0_ready, r1_ready and alu_issue at 0 and SHALL drive alu_op=0.
- REQ-011 The block SHALL arbitrate with r0 priority.
- REQ-012 If r1_valid=1 and the starvation count sc equals STARVE_MAX, the block SHALL grant r1 instead of r0.
- REQ-013 The block SHALL increment sc, saturating at STARVE_MAX, on each r0 grant made while r1_valid=1.
- REQ-014 The block SHALL clear sc on any r1 grant and on any cycle with r1_valid=0.
- REQ-015 Single-cycle issue (multi=0, or SHUF_LAT=1): the block SHALL capture alu_result into rsp_data in the issue cycle and enter RESP on the next cycle, so rsp_valid is visible 1 cycle after issue.
- REQ-016 Multi-cycle issue with SHUF_LAT>1: the block SHALL load cnt=SHUF_LAT-1 and enter BUSY.
- REQ-017 In BUSY, the block SHALL decrement cnt each cycle; when cnt==1 it SHALL capture alu_result into rsp_data and enter RESP, so rsp_valid rises SHUF_LAT cycles after issue.
- REQ-018 The block SHALL register the granted requester's id and tag at issue and hold them stable, together with rsp_data, throughout RESP.
- REQ-019 In RESP with rsp_ready=0, the block SHALL hold all response outputs and accept no new requests.
- REQ-020 In RESP with rsp_ready=1, the block SHALL complete the response handshake; with no valid request it SHALL go to IDLE and drop rsp_valid next cycle, otherwise it SHALL issue per REQ-008/REQ-009 in the same cycle.
- REQ-021 The block SHALL ignore requests arriving during BUSY; requesters hold valid/op/tag until ready.
- REQ-022 flush=1 SHALL take priority over all normal operation: no issue and no ready that cycle; next cycle state=IDLE, rsp_valid=0, cnt=0, sc=0.
- REQ-023 If flush is asserted in RESP together with rsp_ready=1, the handshake SHALL still count as completed; otherwise the response SHALL be discarded.

Reset
- REQ-024 rst=1 SHALL synchronously force IDLE, cnt=0, sc=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0.
- REQ-025 rst SHALL take priority over flush and abort any op mid-BUSY or mid-RESP; no response for that op SHALL ever appear.
- REQ-026 During reset, r0_ready, r1_ready, alu_issue and alu_op SHALL all be 0.

Verification
- REQ-027 The bench SHALL drive r0 single op tag=3 with alu_result=0x55 and rsp_ready=1 -> r0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_data=0x55; back-to-back requests issue every cycle.
- REQ-028 The bench SHALL drive r1 multi op with SHUF_LAT=2, alu_result=0xAB in cycle T+1 -> issue at T; rsp_valid at T+2 with rsp_data=0xAB; r0 requests during T+1 are not accepted.
- REQ-029 The bench SHALL drive r0 and r1 continuously valid, all ops single-cycle, STARVE_MAX=4 -> grant pattern r0,r0,r0,r0,r1 repeating.
- REQ-030 The bench SHALL hold rsp_ready=0 for 5 cycles in RESP -> rsp_id/tag/data held constant, no ready asserted; accepted on the 6th cycle.
- REQ-031 The bench SHALL assert flush in BUSY (SHUF_LAT=4, cycle T+2) -> no rsp_valid; IDLE at T+3; a new r0 request is accepted at T+3.
- REQ-032 The bench SHALL assert rst in RESP with rsp_valid=1 -> next cycle rsp_valid=0 and all outputs 0; the response is never delivered.
